// File: rtl/spi_fifo_drain_arb.sv
// Round-robin drain sequencer for the read sides of N_CH FIFOs sharing one read clock.
// Pops up to BURST_MAX words per grant and presents them on a valid/ready stream.
module spi_fifo_drain_arb #(
  parameter int N_CH      = 4,
  parameter int WIDTH     = 20,
  parameter int BURST_MAX = 8,
  parameter int CH_W      = 2,
  parameter int CNT_W     = 4
) (
  input  logic                  clk,
  input  logic                  aclr_n,
  input  logic                  en,
  input  logic [N_CH-1:0]       rdempty,
  input  logic [N_CH*WIDTH-1:0] fifo_q,
  output logic [N_CH-1:0]       rdreq,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic [CH_W-1:0]       out_chan,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic                  busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] LP_LAST_CNT = CNT_W'(BURST_MAX - 1);
  localparam logic [CH_W-1:0]  LP_LAST_CH  = CH_W'(N_CH - 1);

  state_t            r_state, w_state_nxt;
  logic [CH_W-1:0]   r_ptr, w_ptr_nxt;
  logic [CH_W-1:0]   r_g, w_g_nxt;
  logic [CNT_W-1:0]  r_burst_cnt, w_burst_cnt_nxt;
  logic              r_out_valid, w_out_valid_nxt;
  logic [WIDTH-1:0]  r_out_data, w_out_data_nxt;
  logic              r_out_last, w_out_last_nxt;

  logic              w_found;
  logic [CH_W-1:0]   w_pick;
  logic [CH_W-1:0]   w_idx;

  // Scan ptr, ptr+1, ... downward so the nearest non-empty channel is the last one written.
  // NOTE: every signal assigned in an always_comb gets a default at the top; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      w_idx = CH_W'((int'(r_ptr) + k) % N_CH);
      if (!rdempty[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_ptr_nxt       = r_ptr;
    w_g_nxt         = r_g;
    w_burst_cnt_nxt = r_burst_cnt;
    w_out_valid_nxt = r_out_valid;
    w_out_data_nxt  = r_out_data;
    w_out_last_nxt  = r_out_last;

    unique case (r_state)
      S_IDLE: begin
        if (en && w_found) begin
          w_g_nxt         = w_pick;
          w_burst_cnt_nxt = '0;
          w_state_nxt     = S_FETCH;
        end
      end
      S_FETCH: begin
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        // rdempty here already reflects the pop issued in FETCH, so an emptied FIFO ends the burst.
        w_out_data_nxt  = fifo_q[r_g*WIDTH +: WIDTH];
        w_out_last_nxt  = (r_burst_cnt == LP_LAST_CNT) | rdempty[r_g] | ~en;
        w_out_valid_nxt = 1'b1;
        w_burst_cnt_nxt = r_burst_cnt + 1'b1;
        w_state_nxt     = S_HOLD;
      end
      S_HOLD: begin
        if (r_out_valid && out_ready) begin
          w_out_valid_nxt = 1'b0;
          if (!r_out_last) begin
            w_state_nxt = S_FETCH;
          end else begin
            w_ptr_nxt   = (r_g == LP_LAST_CH) ? '0 : r_g + 1'b1;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_g         <= '0;
      r_burst_cnt <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_g         <= w_g_nxt;
      r_burst_cnt <= w_burst_cnt_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_data  <= w_out_data_nxt;
      r_out_last  <= w_out_last_nxt;
    end
  end

  // Pop decoded from registered state only; the FIFOs have no underflow protection.
  always_comb begin
    rdreq = '0;
    if (r_state == S_FETCH) begin
      rdreq[r_g] = 1'b1;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_chan  = r_g;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: doc/spi_fifo_drain_arb.md
Name: spi_fifo_drain_arb

Overview:
- Round-robin arbiter and read sequencer for the read sides of N_CH dual-clock FIFOs, all read ports on one clock.
- Grants one non-empty channel at a time and pops up to BURST_MAX words from it.
- Presents each word on a valid/ready stream that feeds the SPI transmit path, tagged with channel id and end-of-burst.
- Guarantees no FIFO rdreq is ever issued while that FIFO reports empty, because the FIFOs carry no underflow checking.

Parameters:
- N_CH, 4, number of FIFO channels arbitrated.
- WIDTH, 20, FIFO word width.
- BURST_MAX, 8, maximum words popped per grant (>=1).
- CH_W, 2, width of channel index (clog2(N_CH), minimum 1).
- CNT_W, 4, width of burst counter (clog2(BURST_MAX+1)).

Ports:
- clk  in  1  single clock; rdclk of every drained FIFO.
- aclr_n  in  1  asynchronous active-low reset.
- en  in  1  enable new grants and continuation of bursts.
- rdempty  in  N_CH  per-FIFO registered empty flag.
- fifo_q  in  N_CH*WIDTH  per-FIFO q; channel i at bits [i*WIDTH +: WIDTH].
- rdreq  out  N_CH  per-FIFO pop, one-hot or zero.
- out_valid  out  1  stream word valid.
- out_data  out  WIDTH  stream word.
- out_chan  out  CH_W  source channel of out_data.
- out_last  out  1  final word of current burst.
- out_ready  in  1  downstream accept.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (aclr_n=0, any time, including mid-burst):
  - state=IDLE, ptr=0, grant index g=0, burst_cnt=0.
  - rdreq=0, out_valid=0, out_data=0, out_chan=0, out_last=0, busy=0.
  - A word popped but not yet delivered is discarded.
- rdreq is decoded only from registered state: rdreq = onehot(g) in FETCH, else 0.
  - No combinational path from rdempty or out_ready to rdreq.
- States: IDLE, FETCH, LOAD, HOLD.
- IDLE:
  - If en=1 and any rdempty[i]=0, pick the first non-empty channel searching ptr, ptr+1, ... mod N_CH.
  - Register it in g and out_chan, clear burst_cnt, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH (1 cycle): rdreq[g]=1, go to LOAD. The FIFO's q shows the popped word in the following cycle.
- LOAD (1 cycle):
  - out_data <= fifo_q slice g.
  - out_last <= (burst_cnt==BURST_MAX-1) | rdempty[g] | ~en, where rdempty[g] is already post-pop in this cycle.
  - out_valid <= 1, burst_cnt <= burst_cnt+1, go to HOLD.
- HOLD:
  - out_valid, out_data, out_chan and out_last are held stable until out_ready=1.
  - On a handshake (out_valid & out_ready):
    - out_valid <= 0.
    - If out_last=0, go to FETCH.
    - Else ptr <= (g+1) mod N_CH and go to IDLE.
- out_last is decided at LOAD and never revised. Data written into the FIFO after that point waits for a later grant.
- Throughput: 3 cycles per word with out_ready tied high. First rdreq occurs 1 cycle after IDLE sees a non-empty channel. First out_valid occurs 3 cycles after IDLE sees it.
- Arithmetic:
  - ptr wraps modulo N_CH, including non-power-of-two N_CH.
  - burst_cnt never exceeds BURST_MAX.
- Boundaries:
  - BURST_MAX=1: every word has out_last=1.
  - en falls mid-burst: the current word completes with out_last=1 if not yet loaded. A word already in HOLD is still delivered.
  - All channels empty: the block remains idle and rdreq stays 0.
  - A channel going empty exactly at the pop ends the burst; it is never re-popped while empty.

Test Plan:
- Reset then rdempty=4'b1011, ch2 holds 0x00AAA, out_ready=1:
  - rdreq=4'b0100 for exactly 1 cycle.
  - out_valid for 1 cycle with out_data=0x00AAA, out_chan=2, out_last=1.
  - Next grant search starts at ch3.
- All four channels hold 3 words, BURST_MAX=8:
  - Bursts are served in order ch0, ch1, ch2, ch3.
  - Each burst is 3 words with out_last on the third.
  - 12 words total; no rdreq while rdempty=1.
- Channel 1 holds 20 words, BURST_MAX=8, channel 3 non-empty:
  - Sequence is 8 words ch1 (last on the 8th), then ch3, then ch1 again.
- out_ready held low for 10 cycles in HOLD:
  - out_data, out_chan and out_last stay stable.
  - rdreq=0 throughout.
  - The handshake on release produces exactly one word.
- en dropped during FETCH of word 2 of 5:
  - Word 2 is delivered with out_last=1.
  - The block returns to IDLE and stays there while en=0.
- aclr_n pulsed low during HOLD:
  - All outputs go to 0 immediately (asynchronously).
  - After release, arbitration restarts from ptr=0.
